if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the PC, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes PC_write / IF_ID_write from the hazard detector, redirects from EX (taken branch/JAL/JALR) and the halt request from ID (ecall).
- Produces the IF/ID instruction, PC and valid bit that the ID stage and hazard detector read.

---
 rtl/if_fetch_stage_pkg.sv | 16 +
 rtl/if_fetch_stage_skid.sv | 34 +++
 rtl/if_fetch_stage.sv | 135 +++++++++++++
 tb/tb_if_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: data width, bubble
// instruction and fetch FSM state encodings.
package if_fetch_stage_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_skid.sv
// One-entry {pc, inst} holding register for an instruction that arrives
// while IF/ID is stalled.
module if_skid_buffer
    import if_fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_inst,
    output logic            buf_valid,
    output logic [XLEN-1:0] buf_pc,
    output logic [XLEN-1:0] buf_inst
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_pc    <= '0;
            buf_inst  <= NOP_INST;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_pc    <= load_pc;
            buf_inst  <= load_inst;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory request handshake, skid
// buffer and the IF/ID pipeline register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = if_fetch_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_write,
    input  logic        IF_ID_write,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_inst,
    output logic [31:0] IF_ID_pc,
    output logic        IF_ID_valid,
    output logic        halted,
    output logic [1:0]  fetch_state
);
    import if_fetch_stage_pkg::*;

    // Memory handshake: a transfer happens on any cycle with imem_req=1 and
    // imem_ready=1; once imem_req is raised, imem_addr is held until then.
    fetch_state_t state, state_next;
    logic         halt_pending, halt_pending_next;
    logic [31:0]  pc, req_addr;
    logic         req_pending;
    logic         buf_valid;
    logic [31:0]  buf_pc, buf_inst;
    logic         xfer, fetch_xfer, stall_req, halt_take;
    logic         buf_load, buf_drain, buf_clear;

    assign imem_req   = reset && ((state == DRAIN) ||
                        ((state == FETCH) && !buf_valid && (req_pending || PC_write)));
    assign imem_addr  = req_pending ? req_addr : pc;
    assign xfer       = imem_req && imem_ready;
    assign fetch_xfer = xfer && (state == FETCH);
    assign stall_req  = imem_req && !imem_ready;
    // A same-cycle redirect squashes the (younger) ecall that raised halt.
    assign halt_take  = halt && !redirect && (state == FETCH);

    assign buf_clear  = redirect || halt_take;
    assign buf_load   = fetch_xfer && !IF_ID_write;
    assign buf_drain  = IF_ID_write && buf_valid;

    assign halted      = (state == HALT);
    assign fetch_state = state;

    if_skid_buffer u_skid (
        .clk       (clk),
        .rst_n     (reset),
        .load      (buf_load),
        .drain     (buf_drain),
        .clear     (buf_clear),
        .load_pc   (imem_addr),
        .load_inst (imem_rdata),
        .buf_valid (buf_valid),
        .buf_pc    (buf_pc),
        .buf_inst  (buf_inst)
    );

    always_comb begin
        state_next        = state;
        halt_pending_next = halt_pending;
        case (state)
            FETCH: begin
                if (redirect) begin
                    state_next        = stall_req ? DRAIN : FETCH;
                    halt_pending_next = 1'b0;
                end else if (halt) begin
                    state_next        = stall_req ? DRAIN : HALT;
                    halt_pending_next = stall_req;
                end
            end
            // The outstanding request cannot be cancelled; its data is dropped.
            DRAIN: begin
                if (imem_ready) begin
                    state_next        = halt_pending ? HALT : FETCH;
                    halt_pending_next = 1'b0;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= FETCH;
            halt_pending <= 1'b0;
            pc           <= RESET_PC;
            req_addr     <= RESET_PC;
            req_pending  <= 1'b0;
        end else begin
            state        <= state_next;
            halt_pending <= halt_pending_next;
            req_pending  <= stall_req;
            if (stall_req)
                req_addr <= imem_addr;
            if (redirect)
                pc <= redirect_target;
            else if (fetch_xfer)
                pc <= imem_addr + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IF_ID_inst  <= NOP_INST;
            IF_ID_pc    <= '0;
            IF_ID_valid <= 1'b0;
        end else if (buf_clear) begin
            IF_ID_inst  <= NOP_INST;
            IF_ID_valid <= 1'b0;
        end else if (IF_ID_write) begin
            if (buf_valid) begin
                IF_ID_inst  <= buf_inst;
                IF_ID_pc    <= buf_pc;
                IF_ID_valid <= 1'b1;
            end else if (fetch_xfer) begin
                IF_ID_inst  <= imem_rdata;
                IF_ID_pc    <= imem_addr;
                IF_ID_valid <= 1'b1;
            end else begin
                IF_ID_inst  <= NOP_INST;
                IF_ID_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected IF/ID entries are queued by the
// stimulus and popped by a monitor whenever a new valid instruction appears.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_write, IF_ID_write, redirect, halt;
    logic [31:0] redirect_target;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_ID_inst, IF_ID_pc;
    logic        IF_ID_valid, halted;
    logic [1:0]  fetch_state;

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        upd_q    = 1'b0;

    if_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .PC_write        (PC_write),
        .IF_ID_write     (IF_ID_write),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .IF_ID_inst      (IF_ID_inst),
        .IF_ID_pc        (IF_ID_pc),
        .IF_ID_valid     (IF_ID_valid),
        .halted          (halted),
        .fetch_state     (fetch_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Memory model: the word at address a is a | 0x13.
    assign imem_rdata = imem_addr | 32'h0000_0013;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, pc | 32'h0000_0013});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) upd_q <= reset && IF_ID_write;

    always @(negedge clk) begin
        if (upd_q && IF_ID_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL if_id_unexpected: got pc=%h inst=%h, required no entry",
                         IF_ID_pc, IF_ID_inst);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({IF_ID_pc, IF_ID_inst} !== e) begin
                    n_fail++;
                    $display("FAIL if_id_entry: got pc=%h inst=%h, required pc=%h inst=%h",
                             IF_ID_pc, IF_ID_inst, e[63:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; PC_write = 1'b1; IF_ID_write = 1'b1;
        redirect = 1'b0; redirect_target = '0; halt = 1'b0; imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_inst",  IF_ID_inst,           32'h0000_0013);
        chk("rst_pc",    IF_ID_pc,             32'd0);
        chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rst_halt",  {31'd0, halted},      32'd0);

        // Zero-wait stream
        push_exp(32'd0); push_exp(32'd4); push_exp(32'd8);
        reset = 1'b1;
        @(negedge clk);
        chk("c1_req",  {31'd0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'd0);
        step(); step(); step();

        // Load-use stall: request 12 held pending, lands in skid buffer
        imem_ready = 1'b0; IF_ID_write = 1'b0;
        @(negedge clk);
        chk("lu_addr_a", imem_addr, 32'd12);
        step();
        imem_ready = 1'b1; PC_write = 1'b0;
        @(negedge clk);
        chk("lu_req_pend", {31'd0, imem_req}, 32'd1);
        chk("lu_addr_b",   imem_addr, 32'd12);
        chk("lu_hold_pc",  IF_ID_pc, 32'd8);
        chk("lu_hold_vld", {31'd0, IF_ID_valid}, 32'd1);
        step();
        PC_write = 1'b1; IF_ID_write = 1'b1;
        push_exp(32'd12);
        @(negedge clk);
        chk("lu_no_req", {31'd0, imem_req}, 32'd0);
        step();
        push_exp(32'd16); push_exp(32'd20); push_exp(32'd24); push_exp(32'd28);
        repeat (4) step();

        // Wait-state memory on 0x20 with PC_write toggling
        push_exp(32'h20);
        for (int i = 0; i < 4; i++) begin
            PC_write   = (i % 2 == 0);
            imem_ready = (i == 3);
            @(negedge clk);
            chk("ws_addr", imem_addr, 32'h20);
            chk("ws_req",  {31'd0, imem_req}, 32'd1);
            step();
        end

        // Redirect while a request is outstanding
        PC_write = 1'b1; imem_ready = 1'b1;
        redirect = 1'b1; redirect_target = 32'h40;
        step();
        redirect = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        chk("rd_addr_40", imem_addr, 32'h40);
        step();
        redirect = 1'b1; redirect_target = 32'h100;
        step();
        redirect = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        chk("rd_state_drain", {30'd0, fetch_state}, {30'd0, DRAIN});
        chk("rd_drain_addr",  imem_addr, 32'h40);
        chk("rd_drain_vld",   {31'd0, IF_ID_valid}, 32'd0);
        step();
        push_exp(32'h100);
        @(negedge clk);
        chk("rd_addr_100",   imem_addr, 32'h100);
        chk("rd_state_fetch", {30'd0, fetch_state}, {30'd0, FETCH});
        step();

        // Halt and redirect together: redirect wins
        halt = 1'b1; redirect = 1'b1; redirect_target = 32'h200;
        step();
        halt = 1'b0; redirect = 1'b0;
        push_exp(32'h200);
        @(negedge clk);
        chk("hr_halted",   {31'd0, halted}, 32'd0);
        chk("hr_addr_200", imem_addr, 32'h200);
        step();

        // Halt alone with a request outstanding: drain, then halt
        halt = 1'b1; imem_ready = 1'b0;
        step();
        halt = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        chk("h_state_drain", {30'd0, fetch_state}, {30'd0, DRAIN});
        chk("h_not_yet",     {31'd0, halted}, 32'd0);
        chk("h_drain_addr",  imem_addr, 32'h204);
        step();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("h_req_low", {31'd0, imem_req}, 32'd0);
            chk("h_halted",  {31'd0, halted}, 32'd1);
            step();
        end

        // Asynchronous reset out of HALT
        #3 reset = 1'b0;
        #1;
        chk("ar_halted", {31'd0, halted}, 32'd0);
        chk("ar_pc",     IF_ID_pc, 32'd0);
        chk("ar_state",  {30'd0, fetch_state}, {30'd0, FETCH});
        step();

        // Wrap: redirect to the last word, next fetch at 0
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFC; reset = 1'b1;
        step();
        redirect = 1'b0;
        push_exp(32'hFFFF_FFFC);
        @(negedge clk);
        chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        push_exp(32'd0);
        @(negedge clk);
        chk("wr_addr_zero", imem_addr, 32'd0);
        step();

        // Mid-run reset with a valid instruction held in IF/ID
        PC_write = 1'b0; IF_ID_write = 1'b0;
        step();
        #1;
        chk("mr_pre_vld", {31'd0, IF_ID_valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mr_vld",  {31'd0, IF_ID_valid}, 32'd0);
        chk("mr_inst", IF_ID_inst, 32'h0000_0013);
        chk("mr_req",  {31'd0, imem_req}, 32'd0);
        step();

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
